udma_tx_chan_resp: RTL and testbench

Responder (uDMA-core side) of the peripheral TX data channel. It answers data_tx_req_o from a peripheral such as the SPI master: it grants the request, fetches the word from an L2 memory port, aligns it, and presents data_tx_i/data_tx_valid_i until the peripheral accepts it. It also tracks the channel's start address, size, continuous and pending state, and returns the cfg_tx_* status fields.

---
 rtl/udma_tx_pkg.sv | 38 +++
 rtl/udma_tx_chan_resp_cfg_shadow.sv | 85 ++++++++
 rtl/udma_tx_chan_resp.sv | 197 +++++++++++++++++++
 tb/tb_udma_tx_chan_resp.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udma_tx_pkg.sv
// Shared types and datasize helpers for the uDMA TX channel responder.
package udma_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_FETCH,
    ST_WAIT,
    ST_PRESENT,
    ST_DRAIN
  } state_e;

  localparam logic [1:0] DS_BYTE = 2'd0;
  localparam logic [1:0] DS_HALF = 2'd1;
  localparam logic [1:0] DS_WORD = 2'd2;

  function automatic logic [2:0] ds_step(input logic [1:0] ds);
    case (ds)
      DS_BYTE: return 3'd1;
      DS_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Bytes past the top of the word shift in as zero; no second fetch.
  function automatic logic [31:0] ds_align(input logic [31:0] rdata,
                                           input logic [1:0]  off,
                                           input logic [1:0]  ds);
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    case (ds)
      DS_BYTE: return {24'h0, sh[7:0]};
      DS_HALF: return {16'h0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

endpackage

// File: rtl/udma_tx_chan_resp_cfg_shadow.sv
// Active start/size/continuous registers plus one queued (pending) config.
module udma_tx_cfg_shadow
  import udma_tx_pkg::*;
#(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [L2_AWIDTH_NOAL-1:0] start_i,
  input  logic [TRANS_SIZE-1:0]     size_i,
  input  logic                      cont_i,
  input  logic                      load_i,
  input  logic                      queue_i,
  input  logic                      promote_i,
  input  logic                      clr_i,
  output logic [L2_AWIDTH_NOAL-1:0] start_o,
  output logic [TRANS_SIZE-1:0]     size_o,
  output logic                      cont_o,
  output logic                      pend_o,
  output logic [L2_AWIDTH_NOAL-1:0] sh_start_o,
  output logic [TRANS_SIZE-1:0]     sh_size_o
);

  logic [L2_AWIDTH_NOAL-1:0] start_q, start_d, sh_start_q, sh_start_d;
  logic [TRANS_SIZE-1:0]     size_q, size_d, sh_size_q, sh_size_d;
  logic                      cont_q, cont_d, sh_cont_q, sh_cont_d;
  logic                      pend_q, pend_d;

  always_comb begin
    start_d    = start_q;
    size_d     = size_q;
    cont_d     = cont_q;
    sh_start_d = sh_start_q;
    sh_size_d  = sh_size_q;
    sh_cont_d  = sh_cont_q;
    pend_d     = pend_q;
    if (load_i) begin
      start_d = start_i;
      size_d  = size_i;
      cont_d  = cont_i;
    end else if (promote_i) begin
      start_d = sh_start_q;
      size_d  = sh_size_q;
      cont_d  = sh_cont_q;
    end
    if (promote_i) pend_d = 1'b0;
    // A queue in the same cycle as a promote refills the shadow behind it.
    if (queue_i) begin
      sh_start_d = start_i;
      sh_size_d  = size_i;
      sh_cont_d  = cont_i;
      pend_d     = 1'b1;
    end
    if (clr_i) pend_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q    <= '0;
      size_q     <= '0;
      cont_q     <= 1'b0;
      sh_start_q <= '0;
      sh_size_q  <= '0;
      sh_cont_q  <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      start_q    <= start_d;
      size_q     <= size_d;
      cont_q     <= cont_d;
      sh_start_q <= sh_start_d;
      sh_size_q  <= sh_size_d;
      sh_cont_q  <= sh_cont_d;
      pend_q     <= pend_d;
    end
  end

  assign start_o    = start_q;
  assign size_o     = size_q;
  assign cont_o     = cont_q;
  assign pend_o     = pend_q;
  assign sh_start_o = sh_start_q;
  assign sh_size_o  = sh_size_q;

endmodule

// File: rtl/udma_tx_chan_resp.sv
// uDMA-side responder of a peripheral TX channel: grant, fetch from L2, align, present.
module udma_tx_chan_resp
  import udma_tx_pkg::*;
#(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16
) (
  input  logic                      sys_clk_i,
  input  logic                      rst_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_startaddr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_size_i,
  input  logic                      cfg_continuous_i,
  input  logic                      cfg_en_i,
  input  logic                      cfg_clr_i,
  output logic                      cfg_en_o,
  output logic                      cfg_pending_o,
  output logic [L2_AWIDTH_NOAL-1:0] cfg_curr_addr_o,
  output logic [TRANS_SIZE-1:0]     cfg_bytes_left_o,
  input  logic                      data_tx_req_i,
  output logic                      data_tx_gnt_o,
  input  logic [1:0]                data_tx_datasize_i,
  output logic [31:0]               data_tx_o,
  output logic                      data_tx_valid_o,
  input  logic                      data_tx_ready_i,
  output logic                      mem_req_o,
  output logic [L2_AWIDTH_NOAL-1:0] mem_addr_o,
  input  logic                      mem_gnt_i,
  input  logic [31:0]               mem_rdata_i,
  input  logic                      mem_rvalid_i,
  output logic                      eot_o
);

  state_e                    state_q, state_d;
  logic [L2_AWIDTH_NOAL-1:0] curr_q, curr_d;
  logic [TRANS_SIZE-1:0]     bl_q, bl_d;
  logic [1:0]                ds_q, ds_d;
  logic [31:0]               data_q, data_d;
  logic                      valid_q, valid_d, gnt_q, gnt_d, en_q, en_d, eot_q, eot_d;
  logic                      load, queue, promote, going_idle, en_ok;
  logic [L2_AWIDTH_NOAL-1:0] start, sh_start, adv_addr, step_a;
  logic [TRANS_SIZE-1:0]     size, sh_size, adv_bl, step_t;
  logic                      cont, pend;

  udma_tx_cfg_shadow #(
    .L2_AWIDTH_NOAL(L2_AWIDTH_NOAL),
    .TRANS_SIZE    (TRANS_SIZE)
  ) u_shadow (
    .clk       (sys_clk_i),
    .rst       (rst_i),
    .start_i   (cfg_startaddr_i),
    .size_i    (cfg_size_i),
    .cont_i    (cfg_continuous_i),
    .load_i    (load),
    .queue_i   (queue),
    .promote_i (promote),
    .clr_i     (cfg_clr_i),
    .start_o   (start),
    .size_o    (size),
    .cont_o    (cont),
    .pend_o    (pend),
    .sh_start_o(sh_start),
    .sh_size_o (sh_size)
  );

  always_comb begin
    step_a   = {{(L2_AWIDTH_NOAL-3){1'b0}}, ds_step(ds_q)};
    step_t   = {{(TRANS_SIZE-3){1'b0}}, ds_step(ds_q)};
    adv_addr = curr_q + step_a;
    adv_bl   = (bl_q > step_t) ? (bl_q - step_t) : '0;
    en_ok    = cfg_en_i && (cfg_size_i != '0) && !cfg_clr_i;
  end

  always_comb begin
    state_d    = state_q;
    curr_d     = curr_q;
    bl_d       = bl_q;
    ds_d       = ds_q;
    data_d     = data_q;
    valid_d    = valid_q;
    gnt_d      = 1'b0;
    en_d       = en_q;
    eot_d      = 1'b0;
    load       = 1'b0;
    queue      = 1'b0;
    promote    = 1'b0;
    going_idle = 1'b0;
    case (state_q)
      ST_IDLE: if (en_ok) begin
        load    = 1'b1;
        curr_d  = cfg_startaddr_i;
        bl_d    = cfg_size_i;
        en_d    = 1'b1;
        state_d = ST_ARMED;
      end
      ST_ARMED: if (data_tx_req_i) begin
        ds_d    = data_tx_datasize_i;
        gnt_d   = 1'b1;
        state_d = ST_FETCH;
      end
      ST_FETCH: if (mem_gnt_i) state_d = ST_WAIT;
      ST_WAIT: if (mem_rvalid_i) begin
        data_d  = ds_align(mem_rdata_i, curr_q[1:0], ds_q);
        valid_d = 1'b1;
        state_d = ST_PRESENT;
      end
      ST_PRESENT: if (data_tx_ready_i) begin
        valid_d = 1'b0;
        curr_d  = adv_addr;
        bl_d    = adv_bl;
        state_d = ST_ARMED;
        if (adv_bl == '0) begin
          eot_d = 1'b1;
          if (pend) begin
            promote = 1'b1;
            curr_d  = sh_start;
            bl_d    = sh_size;
          end else if (cont) begin
            curr_d = start;
            bl_d   = size;
          end else begin
            en_d       = 1'b0;
            going_idle = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_DRAIN: if (mem_rvalid_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // An enable landing on the cycle the channel retires starts it afresh.
    if (en_ok && en_q) begin
      if (going_idle) begin
        load    = 1'b1;
        curr_d  = cfg_startaddr_i;
        bl_d    = cfg_size_i;
        en_d    = 1'b1;
        state_d = ST_ARMED;
      end else begin
        queue = 1'b1;
      end
    end
    if (cfg_clr_i) begin
      curr_d  = curr_q;
      bl_d    = '0;
      valid_d = 1'b0;
      gnt_d   = 1'b0;
      en_d    = 1'b0;
      eot_d   = 1'b0;
      load    = 1'b0;
      queue   = 1'b0;
      promote = 1'b0;
      // A granted read still owes an rvalid; swallow it before going idle.
      case (state_q)
        ST_FETCH: state_d = mem_gnt_i ? ST_DRAIN : ST_IDLE;
        ST_WAIT:  state_d = mem_rvalid_i ? ST_IDLE : ST_DRAIN;
        ST_DRAIN: state_d = mem_rvalid_i ? ST_IDLE : ST_DRAIN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      curr_q  <= '0;
      bl_q    <= '0;
      ds_q    <= DS_BYTE;
      data_q  <= '0;
      valid_q <= 1'b0;
      gnt_q   <= 1'b0;
      en_q    <= 1'b0;
      eot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      curr_q  <= curr_d;
      bl_q    <= bl_d;
      ds_q    <= ds_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      gnt_q   <= gnt_d;
      en_q    <= en_d;
      eot_q   <= eot_d;
    end
  end

  assign cfg_en_o         = en_q;
  assign cfg_pending_o    = pend;
  assign cfg_curr_addr_o  = curr_q;
  assign cfg_bytes_left_o = bl_q;
  assign data_tx_gnt_o    = gnt_q;
  assign data_tx_o        = data_q;
  assign data_tx_valid_o  = valid_q;
  assign mem_req_o        = (state_q == ST_FETCH);
  assign mem_addr_o       = {curr_q[L2_AWIDTH_NOAL-1:2], 2'b00};
  assign eot_o            = eot_q;

endmodule

// File: tb/tb_udma_tx_chan_resp.sv
// Directed bench for udma_tx_chan_resp: single-item vector table plus multi-cycle sequences.
module tb_udma_tx_chan_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] startaddr;
  logic [15:0] size;
  logic        cont, en, clr;
  logic        en_o, pend_o;
  logic [11:0] curr_o;
  logic [15:0] bl_o;
  logic        req, gnt_o;
  logic [1:0]  ds;
  logic [31:0] data_o;
  logic        valid_o, ready;
  logic        mem_req, mem_gnt, mem_rvalid;
  logic [11:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        eot;

  logic        gnt_en = 1'b1;
  int          rlat = 1;
  int          cnt = 0;
  logic [11:0] raddr = '0;
  logic [31:0] mem [1024];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign mem_gnt = mem_req & gnt_en;

  udma_tx_chan_resp #(.L2_AWIDTH_NOAL(12), .TRANS_SIZE(16)) dut (
    .sys_clk_i(clk), .rst_i(rst),
    .cfg_startaddr_i(startaddr), .cfg_size_i(size), .cfg_continuous_i(cont),
    .cfg_en_i(en), .cfg_clr_i(clr),
    .cfg_en_o(en_o), .cfg_pending_o(pend_o), .cfg_curr_addr_o(curr_o), .cfg_bytes_left_o(bl_o),
    .data_tx_req_i(req), .data_tx_gnt_o(gnt_o), .data_tx_datasize_i(ds),
    .data_tx_o(data_o), .data_tx_valid_o(valid_o), .data_tx_ready_i(ready),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_gnt_i(mem_gnt),
    .mem_rdata_i(mem_rdata), .mem_rvalid_i(mem_rvalid), .eot_o(eot)
  );

  // L2 model: rvalid arrives rlat cycles after the granted request cycle.
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (rst) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem[raddr[11:2]];
          end
        end
        if (mem_req && mem_gnt) begin
          cnt   = rlat;
          raddr = mem_addr;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic enable(input logic [11:0] a, input logic [15:0] s, input logic c);
    startaddr = a; size = s; cont = c; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic grant();
    logic ok;
    ok  = 1'b0;
    req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt_o) begin
        ok = 1'b1;
        break;
      end
    end
    req = 1'b0;
    if (!ok) chk("gnt_timeout", 32'(ok), 32'd1);
  endtask

  task automatic get_data(output logic [31:0] d);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (valid_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("valid_timeout", 32'(ok), 32'd1);
    d = data_o;
  endtask

  task automatic accept();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic clear();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  typedef struct {
    logic [11:0] addr;
    logic [15:0] size;
    logic [1:0]  ds;
    logic [31:0] exp_data;
    logic [11:0] exp_addr;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [31:0] d;
    logic        flag;

    vecs[0] = '{12'h100, 16'd4, 2'd2, 32'hAABBCCDD, 12'h104};
    vecs[1] = '{12'h102, 16'd1, 2'd0, 32'h000000BB, 12'h103};
    vecs[2] = '{12'h103, 16'd1, 2'd0, 32'h000000AA, 12'h104};
    vecs[3] = '{12'h101, 16'd2, 2'd1, 32'h0000BBCC, 12'h103};
    vecs[4] = '{12'h103, 16'd2, 2'd1, 32'h000000AA, 12'h105};
    vecs[5] = '{12'h102, 16'd4, 2'd2, 32'h0000AABB, 12'h106};
    vecs[6] = '{12'hFFE, 16'd2, 2'd1, 32'h00001234, 12'h000};
    vecs[7] = '{12'h104, 16'd3, 2'd3, 32'h11223344, 12'h108};

    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[12'h000] = 32'hCAFEF00D;
    mem[12'h010] = 32'h0BADBEEF;
    mem[12'h040] = 32'hAABBCCDD;
    mem[12'h041] = 32'h11223344;
    mem[12'h3FF] = 32'h12345678;

    rst = 1'b1; startaddr = '0; size = '0; cont = 1'b0; en = 1'b0; clr = 1'b0;
    req = 1'b0; ds = 2'd0; ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_en", 32'(en_o), 32'd0);
    chk("rst_pend", 32'(pend_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_data", data_o, 32'd0);
    chk("rst_memreq", 32'(mem_req), 32'd0);
    chk("rst_bl", 32'(bl_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // zero-size enable ignored; request outside ARMED never granted
    enable(12'h100, 16'd0, 1'b0);
    chk("zero_size_en", 32'(en_o), 32'd0);
    req = 1'b1; flag = 1'b0;
    repeat (3) begin @(negedge clk); flag |= gnt_o; end
    req = 1'b0;
    chk("idle_no_gnt", 32'(flag), 32'd0);

    // single-item table
    for (int i = 0; i < 8; i++) begin
      ds = vecs[i].ds;
      enable(vecs[i].addr, vecs[i].size, 1'b0);
      grant();
      get_data(d);
      chk($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      accept();
      chk($sformatf("vec%0d_addr", i), 32'(curr_o), 32'(vecs[i].exp_addr));
      chk($sformatf("vec%0d_bl", i), 32'(bl_o), 32'd0);
      chk($sformatf("vec%0d_eot", i), 32'(eot), 32'd1);
      chk($sformatf("vec%0d_en", i), 32'(en_o), 32'd0);
    end

    // two-word transfer
    ds = 2'd2;
    enable(12'h100, 16'd8, 1'b0);
    chk("w_bl0", 32'(bl_o), 32'd8);
    grant(); get_data(d);
    chk("w_data0", d, 32'hAABBCCDD);
    accept();
    chk("w_bl1", 32'(bl_o), 32'd4);
    chk("w_eot1", 32'(eot), 32'd0);
    grant(); get_data(d);
    chk("w_data1", d, 32'h11223344);
    accept();
    chk("w_bl2", 32'(bl_o), 32'd0);
    chk("w_eot2", 32'(eot), 32'd1);
    @(negedge clk);
    chk("w_eot_pulse", 32'(eot), 32'd0);
    chk("w_en", 32'(en_o), 32'd0);

    // byte alignment with re-fetch of the same word
    ds = 2'd0;
    enable(12'h102, 16'd2, 1'b0);
    grant(); get_data(d); chk("b_data0", d, 32'h000000BB); accept();
    grant(); get_data(d); chk("b_data1", d, 32'h000000AA); accept();
    chk("b_addr", 32'(curr_o), 32'h104);

    // backpressure
    ds = 2'd2;
    enable(12'h100, 16'd4, 1'b0);
    grant(); get_data(d);
    flag = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!valid_o || data_o !== d || curr_o !== 12'h100) flag = 1'b0;
    end
    chk("bp_stable", 32'(flag), 32'd1);
    accept();
    chk("bp_addr", 32'(curr_o), 32'h104);

    // pending config takes over at end of transfer
    enable(12'h000, 16'd4, 1'b0);
    grant();
    enable(12'h040, 16'd4, 1'b0);
    chk("p_pend", 32'(pend_o), 32'd1);
    get_data(d); chk("p_data0", d, 32'hCAFEF00D);
    accept();
    chk("p_eot", 32'(eot), 32'd1);
    chk("p_addr", 32'(curr_o), 32'h040);
    chk("p_pend_clr", 32'(pend_o), 32'd0);
    chk("p_en", 32'(en_o), 32'd1);
    grant(); get_data(d); chk("p_data1", d, 32'h0BADBEEF); accept();
    chk("p_en_done", 32'(en_o), 32'd0);

    // continuous reload, then clear while armed
    enable(12'h100, 16'd4, 1'b1);
    grant(); get_data(d); accept();
    chk("c_eot", 32'(eot), 32'd1);
    chk("c_addr", 32'(curr_o), 32'h100);
    chk("c_bl", 32'(bl_o), 32'd4);
    chk("c_en", 32'(en_o), 32'd1);
    cont = 1'b0;
    clear();
    chk("c_clr_en", 32'(en_o), 32'd0);
    chk("c_clr_bl", 32'(bl_o), 32'd0);

    // clear while a request is still unacknowledged
    gnt_en = 1'b0;
    enable(12'h100, 16'd4, 1'b0);
    grant();
    @(negedge clk);
    chk("f_memreq", 32'(mem_req), 32'd1);
    clear();
    chk("f_memreq_drop", 32'(mem_req), 32'd0);
    gnt_en = 1'b1;

    // clear during WAIT: rvalid drained, nothing presented
    rlat = 3;
    enable(12'h100, 16'd4, 1'b0);
    grant();
    @(negedge clk);
    clear();
    flag = 1'b0;
    repeat (8) begin @(negedge clk); flag |= valid_o | eot; end
    chk("d_quiet", 32'(flag), 32'd0);
    chk("d_en", 32'(en_o), 32'd0);
    chk("d_bl", 32'(bl_o), 32'd0);
    rlat = 1;
    enable(12'h104, 16'd4, 1'b0);
    grant(); get_data(d);
    chk("d_after", d, 32'h11223344);
    accept();

    // asynchronous reset mid-PRESENT
    enable(12'h100, 16'd4, 1'b0);
    grant(); get_data(d);
    #2 rst = 1'b1;
    #1;
    chk("r_valid", 32'(valid_o), 32'd0);
    chk("r_en", 32'(en_o), 32'd0);
    chk("r_data", data_o, 32'd0);
    chk("r_bl", 32'(bl_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
